// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding register feeding a start/data/parity/stop shifter.
// Define UART_TX_PARITY_EN to build the parity bit generator and PARITY state.
module uart_tx_serializer (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       transmit_edge,
    output logic       transmit_clk_clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       brk,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_empty,
    output logic [2:0] fsm_state
);

    // Handshake: a byte moves into the holding register on any cycle where
    // tx_valid and tx_ready are both high; tx_valid may drop or change freely
    // otherwise, and tx_ready stays low until the byte has moved to the shifter.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] hold_data;
    logic       hold_empty;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic [1:0] cfg_wls;
    logic       cfg_stb;
    logic       line;
    logic       line_d;
    logic       last_bit;
    logic       frame_end;
    logic       load;
    logic       accept;
    logic       after_data;

`ifdef UART_TX_PARITY_EN
    logic       cfg_pen;
    logic       par_bit;

    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] w,
                                         input logic e, input logic s);
        logic [7:0] mask;
        mask = 8'hff >> (2'd3 - w);
        if (s)
            return ~e;
        else if (e)
            return ^(d & mask);
        else
            return ~^(d & mask);
    endfunction

    assign after_data = cfg_pen ? par_bit : 1'b1;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = ^{pen, eps, sp};
    assign after_data = 1'b1;
`endif

    // Data bits run 0..(4+wls); the last index is simply {1, wls}.
    assign last_bit  = (bit_cnt == {1'b1, cfg_wls});
    assign frame_end = transmit_edge &
                       (((state == S_STOP1) & ~cfg_stb) | (state == S_STOP2));
    assign load      = ~hold_empty & ((state == S_IDLE) | frame_end);
    assign accept    = tx_valid & hold_empty;

    assign tx_ready  = hold_empty;
    assign tx_busy   = (state != S_IDLE);
    assign tx_empty  = hold_empty & (state == S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            hold_empty <= 1'b1;
            hold_data  <= 8'h00;
        end else if (load) begin
            hold_empty <= 1'b1;
        end else if (accept) begin
            hold_empty <= 1'b0;
            hold_data  <= tx_data;
        end
    end

    // Normal (unbroken) line level for the next cycle.
    always_comb begin
        line_d = line;
        if (load) begin
            line_d = 1'b0;
        end else if (transmit_edge) begin
            case (state)
                S_START: line_d = shift[0];
                S_DATA:  line_d = last_bit ? after_data : shift[1];
                default: line_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state            <= S_IDLE;
            shift            <= 8'h00;
            bit_cnt          <= 3'd0;
            cfg_wls          <= 2'd0;
            cfg_stb          <= 1'b0;
            line             <= 1'b1;
            txd              <= 1'b1;
            transmit_clk_clr <= 1'b0;
`ifdef UART_TX_PARITY_EN
            cfg_pen          <= 1'b0;
            par_bit          <= 1'b0;
`endif
        end else begin
            line             <= line_d;
            txd              <= ~brk & line_d;
            // Only frames started from idle realign the baud generator.
            transmit_clk_clr <= load & (state == S_IDLE);
            if (load) begin
                state   <= S_START;
                shift   <= hold_data;
                bit_cnt <= 3'd0;
                cfg_wls <= wls;
                cfg_stb <= stb;
`ifdef UART_TX_PARITY_EN
                cfg_pen <= pen;
                par_bit <= calc_parity(hold_data, wls, eps, sp);
`endif
            end else if (transmit_edge) begin
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_cnt <= 3'd0;
                    end
                    S_DATA: begin
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            state <= cfg_pen ? S_PARITY : S_STOP1;
`else
                            state <= S_STOP1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: state <= S_STOP1;
`endif
                    S_STOP1: state <= cfg_stb ? S_STOP2 : S_IDLE;
                    S_STOP2: state <= S_IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
